// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader packing a byte stream into i_mem words
//
// Purpose: accepts boot bytes over a valid/ready handshake and packs each
// group of four into a 32-bit word, little-endian. Words are written to
// consecutive word addresses starting at 0. The core's fetch stage is held
// stalled while a load is in progress.
//
// Optional feature: define IMEM_LOADER_CSUM_EN to append a one-byte checksum
// to every non-empty load. The load is good when the 8-bit sum of all data
// bytes plus the checksum byte is zero mod 256.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   start, len     begin a load of len words (clamped to DEPTH)
//   in_valid/in_byte/in_ready   boot byte handshake
//   wr_addr0/wr_din0/we0        i_mem write port (byte address, word, strobe)
//   core_hold, busy             load in progress
//   done                        sticky completion flag
//   word_cnt                    words written in the current load
//   csum_err                    checksum mismatch (0 when the feature is off)
module imem_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CW-1:0]    len,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    output logic [31:0]      wr_addr0,
    output logic [WIDTH-1:0] wr_din0,
    output logic             we0,
    output logic             core_hold,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    word_cnt,
    output logic             csum_err
);

`ifdef IMEM_LOADER_CSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

    state_t        state;
    logic [CW-1:0] len_eff;
    logic [1:0]    byte_idx;
    logic [23:0]   word_q;     // lanes 0..2; lane 3 goes straight to wr_din0
    logic [CW-1:0] cnt_next;

    assign cnt_next = word_cnt + CW'(1);

    // Handshake and status strobes depend on the state register only.
    assign we0 = (state == WRITE);
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] sum;
    assign in_ready = (state == RECV) || (state == CHECK);
    assign busy     = (state == RECV) || (state == WRITE) || (state == CHECK);
`else
    assign in_ready = (state == RECV);
    assign busy     = (state == RECV) || (state == WRITE);
    assign csum_err = 1'b0;
`endif
    assign core_hold = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len_eff  <= '0;
            byte_idx <= '0;
            word_q   <= '0;
            word_cnt <= '0;
            wr_addr0 <= '0;
            wr_din0  <= '0;
            done     <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            sum      <= '0;
            csum_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len_eff  <= (len > CW'(DEPTH)) ? CW'(DEPTH) : len;
                        word_cnt <= '0;
                        byte_idx <= '0;
                        word_q   <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                        sum      <= '0;
                        csum_err <= 1'b0;
`endif
                        // A zero-length load completes immediately.
                        if (len == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            done  <= 1'b0;
                            state <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                        sum      <= sum + in_byte;
`endif
                        case (byte_idx)
                            2'd0: word_q[7:0]   <= in_byte;
                            2'd1: word_q[15:8]  <= in_byte;
                            2'd2: word_q[23:16] <= in_byte;
                            default: begin
                                // Present address and data for the WRITE cycle.
                                wr_din0  <= {in_byte, word_q};
                                wr_addr0 <= {{(32-CW-2){1'b0}}, word_cnt, 2'b00};
                                state    <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    word_cnt <= cnt_next;
                    if (cnt_next == len_eff) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state <= CHECK;
`else
                        done  <= 1'b1;
                        state <= DONE;
`endif
                    end else begin
                        state <= RECV;
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                CHECK: begin
                    if (in_valid) begin
                        csum_err <= ((sum + in_byte) != 8'd0);
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
